// File: rtl/rr_stream_mux.sv
`default_nettype none
// ============================================================================
// Module   : rr_stream_mux
// Brief    : N-channel stream multiplexer with a single-entry registered
//            output stage. Grants either a fixed channel chosen by 'control'
//            or rotates round-robin across valid channels.
// Revision : 1.0 - initial release
// ============================================================================
module rr_stream_mux #(
    parameter int WIDTH = 32,
    parameter int N     = 4,
    parameter int SELW  = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_valid,
    output logic [N-1:0]         in_ready,
    input  logic                 mode,
    input  logic [SELW-1:0]      control,
    output logic [WIDTH-1:0]     out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [SELW-1:0]      out_chan
);

    // Pointer value after reset: the first round-robin search begins at 0.
    localparam logic [SELW-1:0] c_ptr_init = SELW'(N - 1);

    // Registered state
    logic [WIDTH-1:0] r_data;
    logic [SELW-1:0]  r_chan;
    logic             r_valid;
    logic [SELW-1:0]  r_ptr;

    // Combinational arbitration signals
    logic             w_load_en;
    logic             w_fix_grant;
    logic [SELW-1:0]  w_fix_idx;
    logic             w_rr_grant;
    logic [SELW-1:0]  w_rr_idx;
    logic [SELW-1:0]  w_cand;
    logic             w_grant;
    logic [SELW-1:0]  w_grant_idx;
    logic             w_xfer;
    logic [WIDTH-1:0] w_grant_data;

    // The output register may take a new word when empty or being drained.
    assign w_load_en = !r_valid || out_ready;

    // Fixed mode: grant the channel named by control only if it exists and is
    // valid. Comparing against each legal index means an out-of-range control
    // value simply matches nothing.
    always_comb begin
        w_fix_grant = 1'b0;
        w_fix_idx   = '0;
        for (int i = 0; i < N; i++) begin
            if ((control == SELW'(i)) && in_valid[i]) begin
                w_fix_grant = 1'b1;
                w_fix_idx   = SELW'(i);
            end
        end
    end

    // Round-robin: search offsets ptr+1 .. ptr+N (mod N). Walking the offsets
    // from farthest to nearest lets the nearest valid channel win last, and
    // the pointer's own channel (offset N) has the lowest priority.
    always_comb begin
        w_rr_grant = 1'b0;
        w_rr_idx   = '0;
        w_cand     = '0;
        for (int k = N; k >= 1; k--) begin
            w_cand = SELW'((int'(r_ptr) + k) % N);
            if (in_valid[w_cand]) begin
                w_rr_grant = 1'b1;
                w_rr_idx   = w_cand;
            end
        end
    end

    // Pick the active arbiter; a transfer needs a grant, room in the output
    // register and no reset in progress.
    assign w_grant     = mode ? w_rr_grant : w_fix_grant;
    assign w_grant_idx = mode ? w_rr_idx   : w_fix_idx;
    assign w_xfer      = w_grant && w_load_en && !reset;

    // Select the granted channel's word from the packed input bus.
    always_comb begin
        w_grant_data = '0;
        for (int i = 0; i < N; i++) begin
            if (w_grant_idx == SELW'(i)) begin
                w_grant_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // One-hot ready back to the granted channel only when the word is taken.
    always_comb begin
        in_ready = '0;
        for (int i = 0; i < N; i++) begin
            in_ready[i] = w_xfer && (w_grant_idx == SELW'(i));
        end
    end

    // Output register and round-robin pointer: load on transfer, clear the
    // valid flag on a drain with no replacement, otherwise hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data  <= '0;
            r_chan  <= '0;
            r_valid <= 1'b0;
            r_ptr   <= c_ptr_init;
        end else if (w_xfer) begin
            r_data  <= w_grant_data;
            r_chan  <= w_grant_idx;
            r_valid <= 1'b1;
            r_ptr   <= w_grant_idx;
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign out_data  = r_data;
    assign out_chan  = r_chan;
    assign out_valid = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_rr_stream_mux.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_stream_mux
// Brief    : Directed self-checking bench for rr_stream_mux, using a 4-channel
//            and a 3-channel instance sharing clock and reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_stream_mux;

    localparam int c_w  = 8;
    localparam int c_n4 = 4;
    localparam int c_n3 = 3;

    logic clk;
    logic reset;

    // 4-channel instance signals
    logic [c_n4*c_w-1:0] in_data4;
    logic [c_n4-1:0]     in_valid4;
    logic [c_n4-1:0]     in_ready4;
    logic                mode4;
    logic [1:0]          control4;
    logic [c_w-1:0]      out_data4;
    logic                out_valid4;
    logic                out_ready4;
    logic [1:0]          out_chan4;

    // 3-channel instance signals
    logic [c_n3*c_w-1:0] in_data3;
    logic [c_n3-1:0]     in_valid3;
    logic [c_n3-1:0]     in_ready3;
    logic                mode3;
    logic [1:0]          control3;
    logic [c_w-1:0]      out_data3;
    logic                out_valid3;
    logic                out_ready3;
    logic [1:0]          out_chan3;

    int n_cmp;
    int n_err;

    rr_stream_mux #(.WIDTH(c_w), .N(c_n4)) u_dut4 (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data4),
        .in_valid  (in_valid4),
        .in_ready  (in_ready4),
        .mode      (mode4),
        .control   (control4),
        .out_data  (out_data4),
        .out_valid (out_valid4),
        .out_ready (out_ready4),
        .out_chan  (out_chan4)
    );

    rr_stream_mux #(.WIDTH(c_w), .N(c_n3)) u_dut3 (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data3),
        .in_valid  (in_valid3),
        .in_ready  (in_ready3),
        .mode      (mode3),
        .control   (control3),
        .out_data  (out_data3),
        .out_valid (out_valid3),
        .out_ready (out_ready3),
        .out_chan  (out_chan3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts and reports mismatches.
    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one edge, then settle so outputs are sampled away from the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;

        reset      = 1'b1;
        in_data4   = {8'h23, 8'h22, 8'h21, 8'h20};
        in_valid4  = 4'b1111;
        mode4      = 1'b1;
        control4   = 2'd0;
        out_ready4 = 1'b1;
        in_data3   = {8'h32, 8'h31, 8'h30};
        in_valid3  = 3'b111;
        mode3      = 1'b0;
        control3   = 2'd3;
        out_ready3 = 1'b1;

        // Reset state; ready must stay low while reset is high.
        tick();
        tick();
        check("rst_valid", out_valid4, 1'b0);
        check("rst_data",  out_data4,  8'h00);
        check("rst_chan",  out_chan4,  2'd0);
        check("rst_ready", in_ready4,  4'b0000);
        reset = 1'b0;
        #1;

        // Round-robin with all channels valid: 0,1,2,3,0.
        check("rr_first_ready", in_ready4, 4'b0001);
        for (int s = 0; s < 5; s++) begin
            automatic logic [1:0] exp_ch = 2'(s % 4);
            tick();
            check("rr_chan",  out_chan4,  exp_ch);
            check("rr_valid", out_valid4, 1'b1);
            check("rr_data",  out_data4,  8'h20 + 8'(exp_ch));
        end

        // Fixed mode, control=2, channel 2 not valid: drained, no new grant.
        mode4     = 1'b0;
        control4  = 2'd2;
        in_valid4 = 4'b1011;
        #1;
        check("fix_nogrant_ready", in_ready4, 4'b0000);
        tick();
        check("fix_nogrant_valid", out_valid4, 1'b0);
        check("fix_retain_data",   out_data4,  8'h20);
        tick();
        check("fix_nogrant_valid2", out_valid4, 1'b0);

        // Channel 2 becomes valid with 0xA5.
        in_data4[2*c_w +: c_w] = 8'hA5;
        in_valid4 = 4'b0100;
        #1;
        check("fix_ready", in_ready4, 4'b0100);
        tick();
        check("fix_data",  out_data4,  8'hA5);
        check("fix_chan",  out_chan4,  2'd2);
        check("fix_valid", out_valid4, 1'b1);

        // Drain 0xA5 and load 0x11 from channel 3 in the same edge.
        control4  = 2'd3;
        in_valid4 = 4'b1111;
        in_data4[3*c_w +: c_w] = 8'h11;
        tick();
        check("swap_data",  out_data4,  8'h11);
        check("swap_valid", out_valid4, 1'b1);

        // Backpressure for 3 cycles, round-robin selected but nothing moves.
        out_ready4 = 1'b0;
        mode4      = 1'b1;
        for (int s = 0; s < 3; s++) begin
            #1;
            check("bp_ready", in_ready4, 4'b0000);
            tick();
            check("bp_data",  out_data4,  8'h11);
            check("bp_chan",  out_chan4,  2'd3);
            check("bp_valid", out_valid4, 1'b1);
        end

        // Release: ptr=3, so channel 0 loads in the draining edge.
        out_ready4 = 1'b1;
        #1;
        check("rel_ready", in_ready4, 4'b0001);
        tick();
        check("rel_chan",  out_chan4,  2'd0);
        check("rel_data",  out_data4,  8'h20);
        check("rel_valid", out_valid4, 1'b1);

        // Reset while holding a word under backpressure.
        out_ready4 = 1'b0;
        reset      = 1'b1;
        out_ready4 = 1'b1;
        #1;
        check("rst2_ready", in_ready4, 4'b0000);
        out_ready4 = 1'b0;
        #1;
        tick();
        check("rst2_valid", out_valid4, 1'b0);
        check("rst2_data",  out_data4,  8'h00);
        check("rst2_chan",  out_chan4,  2'd0);
        reset      = 1'b0;
        out_ready4 = 1'b1;
        #1;
        check("rst2_rr_ready", in_ready4, 4'b0001);
        tick();
        check("rst2_rr_chan", out_chan4, 2'd0);
        check("rst2_rr_data", out_data4, 8'h20);

        // 3-channel instance: control=3 is out of range, never granted.
        check("n3_oor_ready", in_ready3, 3'b000);
        check("n3_oor_valid", out_valid3, 1'b0);
        tick();
        check("n3_oor_valid2", out_valid3, 1'b0);

        // Legal fixed index 2 on the 3-channel instance.
        control3 = 2'd2;
        #1;
        check("n3_fix_ready", in_ready3, 3'b100);
        tick();
        check("n3_fix_chan", out_chan3, 2'd2);
        check("n3_fix_data", out_data3, 8'h32);

        // Round-robin from ptr=2 wraps at a non power-of-two count: 0,1,2,0.
        mode3 = 1'b1;
        for (int s = 0; s < 4; s++) begin
            automatic logic [1:0] exp_ch = 2'(s % 3);
            tick();
            check("n3_rr_chan", out_chan3, exp_ch);
            check("n3_rr_data", out_data3, 8'h30 + 8'(exp_ch));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
